// File: rtl/dkong_wav_rom_arbiter_pkg.sv
// Shared definitions for the Donkey Kong sound ROM arbiter.
//  - state_t : arbiter FSM encodings (2-bit)
//  - ch_t    : requester channel IDs (CPU fetch, wave fetcher, aux voice)
//  - ROM_LAT_MAX : largest supported ROM read latency (fits the 3-bit counter)
package dkong_snd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CH_CPU = 2'd0,
    CH_WAV = 2'd1,
    CH_AUX = 2'd2
  } ch_t;

  localparam int ROM_LAT_MAX = 7;

endpackage

// File: rtl/dkong_wav_rom_arbiter_if.sv
// Bus bundle between the sound sub-blocks, the arbiter and the ROM read port.
//  Requester side : I_REQ[2:0], I_ADDR0..2 in; O_ACK[2:0], O_DATA, O_BUSY out
//  ROM side       : O_ROM_AB, O_ROM_RD out; I_ROM_DB in
//  slave  modport : the arbiter
//  master modport : whoever drives requests and models the ROM
interface dkong_wav_rom_arbiter_if #(
  parameter int AW = 19
);
  logic [2:0]    I_REQ;
  logic [AW-1:0] I_ADDR0;
  logic [AW-1:0] I_ADDR1;
  logic [AW-1:0] I_ADDR2;
  logic [2:0]    O_ACK;
  logic [7:0]    O_DATA;
  logic          O_BUSY;
  logic [AW-1:0] O_ROM_AB;
  logic          O_ROM_RD;
  logic [7:0]    I_ROM_DB;

  modport slave (
    input  I_REQ, I_ADDR0, I_ADDR1, I_ADDR2, I_ROM_DB,
    output O_ACK, O_DATA, O_BUSY, O_ROM_AB, O_ROM_RD
  );

  modport master (
    output I_REQ, I_ADDR0, I_ADDR1, I_ADDR2, I_ROM_DB,
    input  O_ACK, O_DATA, O_BUSY, O_ROM_AB, O_ROM_RD
  );
endinterface

// File: rtl/dkong_wav_rom_arbiter_prio_rr.sv
// Combinational 3-way grant for the sound ROM arbiter.
//  req[2:0]  in  : per-channel request levels
//  rr_last   in  : last of ch1/ch2 that was granted
//  grant[2:0] out: one-hot grant, all zero when nothing is requested
// ch0 (sound CPU) always wins; ch1 and ch2 take turns when both ask.
module dkong_snd_prio_rr
  import dkong_snd_pkg::*;
(
  input  logic [2:0] req,
  input  ch_t        rr_last,
  output logic [2:0] grant
);

  always_comb begin
    grant = 3'b000;
    if (req[CH_CPU]) begin
      grant = 3'b001;
    end else if (req[CH_WAV] && req[CH_AUX]) begin
      // Contention between the two round-robin channels: hand it to
      // whichever one was not served last.
      grant = (rr_last == CH_WAV) ? 3'b100 : 3'b010;
    end else if (req[CH_WAV]) begin
      grant = 3'b010;
    end else if (req[CH_AUX]) begin
      grant = 3'b100;
    end
  end

endmodule

// File: rtl/dkong_wav_rom_arbiter.sv
// Shares the single 8-bit wave/sample ROM port between three requesters
// (ch0 sound CPU, ch1 walk/jump/foot wave fetcher, ch2 auxiliary voice).
//  I_CLK  in : system clock, rising edge
//  I_RSTn in : asynchronous active-low reset
//  bus       : slave side of dkong_wav_rom_arbiter_if (requests, acks, ROM port)
// Parameters: ROM_LAT (1..ROM_LAT_MAX) cycles from the read strobe to valid
// ROM data; AW is the ROM byte-address width.
// Every output is registered, so nothing on the request side reaches an
// output combinationally.
module dkong_wav_rom_arbiter
  import dkong_snd_pkg::*;
#(
  parameter int ROM_LAT = 1,
  parameter int AW      = 19
) (
  input  logic                   I_CLK,
  input  logic                   I_RSTn,
  dkong_wav_rom_arbiter_if.slave bus
);

  // WAIT lasts ROM_LAT cycles, so the down-counter starts one short of it.
  localparam logic [2:0] LAT_LOAD = 3'(ROM_LAT - 1);

  state_t        state;
  ch_t           rr_last;
  logic [2:0]    grant;
  logic [2:0]    grant_q;
  logic [2:0]    lat_cnt;
  logic [AW-1:0] sel_addr;

  dkong_snd_prio_rr u_prio (
    .req     (bus.I_REQ),
    .rr_last (rr_last),
    .grant   (grant)
  );

  always_comb begin
    sel_addr = bus.I_ADDR0;
    if (grant[CH_WAV]) begin
      sel_addr = bus.I_ADDR1;
    end else if (grant[CH_AUX]) begin
      sel_addr = bus.I_ADDR2;
    end
  end

  // O_ROM_AB deliberately keeps its value outside ISSUE; only O_ROM_RD
  // marks a real read. rr_last starts at ch2 so ch1 is preferred first,
  // and a ch0 grant leaves the round-robin order untouched.
  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state        <= ST_IDLE;
      rr_last      <= CH_AUX;
      grant_q      <= 3'b000;
      lat_cnt      <= 3'd0;
      bus.O_ACK    <= 3'b000;
      bus.O_DATA   <= 8'h00;
      bus.O_BUSY   <= 1'b0;
      bus.O_ROM_AB <= '0;
      bus.O_ROM_RD <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            grant_q      <= grant;
            bus.O_ROM_AB <= sel_addr;
            bus.O_ROM_RD <= 1'b1;
            bus.O_BUSY   <= 1'b1;
            state        <= ST_ISSUE;
            if (!grant[CH_CPU]) begin
              rr_last <= grant[CH_WAV] ? CH_WAV : CH_AUX;
            end
          end
        end
        ST_ISSUE: begin
          bus.O_ROM_RD <= 1'b0;
          lat_cnt      <= LAT_LOAD;
          state        <= ST_WAIT;
        end
        ST_WAIT: begin
          if (lat_cnt == 3'd0) begin
            bus.O_DATA <= bus.I_ROM_DB;
            bus.O_ACK  <= grant_q;
            state      <= ST_DONE;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        ST_DONE: begin
          bus.O_ACK  <= 3'b000;
          bus.O_BUSY <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
